// File: rtl/sdp_ram_if.sv
// Bus bundle for sdp_ram_pipelined: write port, read port, clear request and status.
// The master side drives requests; the slave side (the RAM) drives busy/q/q_valid/addr_err.
interface sdp_ram_if #(
  parameter int DATA_WIDTH = 8,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
);
  localparam int NUM_LANES = DATA_WIDTH / BYTE_WIDTH;

  logic                  clear_start;
  logic                  busy;
  logic                  we;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [DATA_WIDTH-1:0] data;
  logic [NUM_LANES-1:0]  byte_en;
  logic                  re;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic [DATA_WIDTH-1:0] q;
  logic                  q_valid;
  logic                  addr_err;

  modport master (
    output clear_start, we, write_addr, data, byte_en, re, read_addr,
    input  busy, q, q_valid, addr_err
  );

  modport slave (
    input  clear_start, we, write_addr, data, byte_en, re, read_addr,
    output busy, q, q_valid, addr_err
  );
endinterface

// File: rtl/sdp_ram_pipelined.sv
// Simple dual-port RAM with byte enables, 1/2-cycle registered read and a clear sweep.
// Define SDP_RAM_BYPASS_EN for write-first read-during-write; otherwise read-first.
module sdp_ram_pipelined #(
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    BYTE_WIDTH   = 8,
  parameter int                    MEM_DEPTH    = 4,
  parameter int                    ADDR_WIDTH   = (MEM_DEPTH > 2) ? $clog2(MEM_DEPTH) : 1,
  parameter int                    READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0
) (
  input logic      clk,
  input logic      reset,
  sdp_ram_if.slave bus
);
  localparam int                    NUM_LANES = DATA_WIDTH / BYTE_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [0:0]            ST_CLEAR  = 1'b0;
  localparam logic [0:0]            ST_READY  = 1'b1;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return ({{(32-ADDR_WIDTH){1'b0}}, a} < 32'(MEM_DEPTH));
  endfunction

`ifdef SDP_RAM_BYPASS_EN
  function automatic logic [DATA_WIDTH-1:0] merge_lanes(input logic [DATA_WIDTH-1:0] old_word,
                                                        input logic [DATA_WIDTH-1:0] new_word,
                                                        input logic [NUM_LANES-1:0]  mask);
    logic [DATA_WIDTH-1:0] r;
    r = old_word;
    for (int i = 0; i < NUM_LANES; i++)
      if (mask[i]) r[i*BYTE_WIDTH +: BYTE_WIDTH] = new_word[i*BYTE_WIDTH +: BYTE_WIDTH];
    return r;
  endfunction
`endif

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  ready, rd_acc, wr_acc, err_p0;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [NUM_LANES-1:0]  mem_wmask;
  logic [DATA_WIDTH-1:0] rd_word_p0;
  logic                  rd_vld_p1_q, rd_vld_p1_d;
  logic                  addr_err_q, addr_err_d;
  logic [DATA_WIDTH-1:0] q_out;
  logic                  q_vld;

  // Stage p0: request acceptance, clear sequencing and memory write
  always_comb begin
    ready  = (state_q == ST_READY) && !reset;
    rd_acc = ready && bus.re;
    wr_acc = ready && bus.we && in_range(bus.write_addr);
    err_p0 = ready && ((bus.we && !in_range(bus.write_addr)) ||
                       (bus.re && !in_range(bus.read_addr)));
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LAST_ADDR) begin
          state_d = ST_READY;
          ptr_d   = '0;
        end
      end
      default: begin
        if (bus.clear_start) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // The sweep writes whole words; byte_en only matters for user writes.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = ptr_q;
    mem_wdata = CLEAR_VALUE;
    mem_wmask = '1;
    if (!reset) begin
      if (state_q == ST_CLEAR) begin
        mem_we = 1'b1;
      end else if (wr_acc) begin
        mem_we    = 1'b1;
        mem_waddr = bus.write_addr;
        mem_wdata = bus.data;
        mem_wmask = bus.byte_en;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      for (int i = 0; i < NUM_LANES; i++)
        if (mem_wmask[i])
          mem_q[mem_waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= mem_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
  end

  always_comb begin
    rd_word_p0 = '0;
    if (in_range(bus.read_addr)) rd_word_p0 = mem_q[bus.read_addr];
`ifdef SDP_RAM_BYPASS_EN
    if (wr_acc && (bus.write_addr == bus.read_addr))
      rd_word_p0 = merge_lanes(rd_word_p0, bus.data, bus.byte_en);
`endif
  end

  // Stage p1: captured read word, valid and address-error strobe
  always_comb begin
    rd_vld_p1_d = rd_acc;
    addr_err_d  = err_p0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld_p1_q <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      rd_vld_p1_q <= rd_vld_p1_d;
      addr_err_q  <= addr_err_d;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] rd_data_p1_q, rd_data_p1_d;
    logic [DATA_WIDTH-1:0] rd_data_p2_q, rd_data_p2_d;
    logic                  rd_vld_p2_q, rd_vld_p2_d;

    always_comb begin
      rd_data_p1_d = rd_acc ? rd_word_p0 : rd_data_p1_q;
      rd_data_p2_d = rd_vld_p1_q ? rd_data_p1_q : rd_data_p2_q;
      rd_vld_p2_d  = rd_vld_p1_q;
    end

    always_ff @(posedge clk) rd_data_p1_q <= rd_data_p1_d;

    // Stage p2: output register, q holds between strobes
    always_ff @(posedge clk) begin
      if (reset) begin
        rd_data_p2_q <= '0;
        rd_vld_p2_q  <= 1'b0;
      end else begin
        rd_data_p2_q <= rd_data_p2_d;
        rd_vld_p2_q  <= rd_vld_p2_d;
      end
    end

    assign q_out = rd_data_p2_q;
    assign q_vld = rd_vld_p2_q;
  end else begin : g_lat1
    logic [DATA_WIDTH-1:0] rd_data_p1_q, rd_data_p1_d;

    always_comb rd_data_p1_d = rd_acc ? rd_word_p0 : rd_data_p1_q;

    always_ff @(posedge clk) begin
      if (reset) rd_data_p1_q <= '0;
      else       rd_data_p1_q <= rd_data_p1_d;
    end

    assign q_out = rd_data_p1_q;
    assign q_vld = rd_vld_p1_q;
  end

  assign bus.busy     = (state_q == ST_CLEAR) || reset;
  assign bus.q        = q_out;
  assign bus.q_valid  = q_vld;
  assign bus.addr_err = addr_err_q;
endmodule

// File: tb/tb_sdp_ram_pipelined.sv
// Scoreboard bench: dut_a (16b, depth 5, latency 1) and dut_b (16b, depth 4, latency 2, clear 0x5AA5).
module tb_sdp_ram_pipelined;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  sdp_ram_if #(.DATA_WIDTH(16), .BYTE_WIDTH(8), .ADDR_WIDTH(3)) ifa ();
  sdp_ram_if #(.DATA_WIDTH(16), .BYTE_WIDTH(8), .ADDR_WIDTH(2)) ifb ();

  sdp_ram_pipelined #(.DATA_WIDTH(16), .BYTE_WIDTH(8), .MEM_DEPTH(5), .ADDR_WIDTH(3),
                      .READ_LATENCY(1), .CLEAR_VALUE(16'h0000))
    dut_a (.clk(clk), .reset(rst_a), .bus(ifa.slave));

  sdp_ram_pipelined #(.DATA_WIDTH(16), .BYTE_WIDTH(8), .MEM_DEPTH(4), .ADDR_WIDTH(2),
                      .READ_LATENCY(2), .CLEAR_VALUE(16'h5AA5))
    dut_b (.clk(clk), .reset(rst_b), .bus(ifb.slave));

`ifdef SDP_RAM_BYPASS_EN
  localparam logic [15:0] RDW_FULL = 16'h005A;
  localparam logic [15:0] RDW_PART = 16'h9911;
`else
  localparam logic [15:0] RDW_FULL = 16'h0000;
  localparam logic [15:0] RDW_PART = 16'h9900;
`endif

  typedef struct {
    logic [15:0] d;
    int          c;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic a_cyc(input logic we, input logic [2:0] wa, input logic [15:0] d,
                       input logic [1:0] be, input logic re, input logic [2:0] ra);
    ifa.we = we; ifa.write_addr = wa; ifa.data = d; ifa.byte_en = be;
    ifa.re = re; ifa.read_addr = ra;
    nxt();
    ifa.we = 1'b0; ifa.re = 1'b0; ifa.byte_en = 2'b00;
  endtask

  task automatic b_cyc(input logic cs, input logic we, input logic [1:0] wa, input logic [15:0] d,
                       input logic [1:0] be, input logic re, input logic [1:0] ra);
    ifb.clear_start = cs; ifb.we = we; ifb.write_addr = wa; ifb.data = d; ifb.byte_en = be;
    ifb.re = re; ifb.read_addr = ra;
    nxt();
    ifb.clear_start = 1'b0; ifb.we = 1'b0; ifb.re = 1'b0; ifb.byte_en = 2'b00;
  endtask

  task automatic a_exp(input logic [15:0] d);
    exp_t e;
    e.d = d; e.c = cyc;
    qa.push_back(e);
  endtask

  task automatic b_exp(input logic [15:0] d);
    exp_t e;
    e.d = d; e.c = cyc;
    qb.push_back(e);
  endtask

  task automatic a_wr(input logic [2:0] wa, input logic [15:0] d, input logic [1:0] be);
    a_cyc(1'b1, wa, d, be, 1'b0, 3'd0);
  endtask

  task automatic a_rd(input logic [2:0] ra, input logic [15:0] d);
    a_exp(d);
    a_cyc(1'b0, 3'd0, 16'h0, 2'b00, 1'b1, ra);
  endtask

  task automatic b_wr(input logic [1:0] wa, input logic [15:0] d);
    b_cyc(1'b0, 1'b1, wa, d, 2'b11, 1'b0, 2'd0);
  endtask

  task automatic b_rd(input logic [1:0] ra, input logic [15:0] d);
    b_exp(d);
    b_cyc(1'b0, 1'b0, 2'd0, 16'h0, 2'b00, 1'b1, ra);
  endtask

  task automatic count_busy_a(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ifa.busy === 1'b1) n++;
      else break;
    end
  endtask

  task automatic count_busy_b(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ifb.busy === 1'b1) n++;
      else break;
    end
  endtask

  always @(negedge clk) begin
    if (ifa.q_valid === 1'b1) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_valid q=%0h expected no strobe (t=%0t)", ifa.q, $time);
      end else begin
        ea = qa.pop_front();
        chk("a_q", 32'(ifa.q), 32'(ea.d));
        chk("a_latency", 32'(cyc - ea.c), 32'd1);
      end
    end
  end

  always @(negedge clk) begin
    if (ifb.q_valid === 1'b1) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_valid q=%0h expected no strobe (t=%0t)", ifb.q, $time);
      end else begin
        eb = qb.pop_front();
        chk("b_q", 32'(ifb.q), 32'(eb.d));
        chk("b_latency", 32'(cyc - eb.c), 32'd2);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int na, nb;
    rst_a = 1'b1; rst_b = 1'b1;
    ifa.clear_start = 1'b0; ifa.we = 1'b0; ifa.write_addr = '0; ifa.data = '0;
    ifa.byte_en = '0; ifa.re = 1'b0; ifa.read_addr = '0;
    ifb.clear_start = 1'b0; ifb.we = 1'b0; ifb.write_addr = '0; ifb.data = '0;
    ifb.byte_en = '0; ifb.re = 1'b0; ifb.read_addr = '0;
    repeat (2) nxt();

    @(negedge clk);
    chk("rst_a_q", 32'(ifa.q), 32'h0);
    chk("rst_a_q_valid", 32'(ifa.q_valid), 32'h0);
    chk("rst_a_addr_err", 32'(ifa.addr_err), 32'h0);
    chk("rst_a_busy", 32'(ifa.busy), 32'h1);
    chk("rst_b_q", 32'(ifb.q), 32'h0);
    chk("rst_b_q_valid", 32'(ifb.q_valid), 32'h0);
    chk("rst_b_busy", 32'(ifb.busy), 32'h1);
    nxt();
    rst_a = 1'b0; rst_b = 1'b0;

    fork
      count_busy_a(na);
      count_busy_b(nb);
    join
    chk("a_busy_cycles", 32'(na), 32'd5);
    chk("b_busy_cycles", 32'(nb), 32'd4);
    nxt();

    // Cleared contents, including the last address of each memory
    for (int i = 0; i < 5; i++) a_rd(3'(i), 16'h0000);
    for (int i = 0; i < 4; i++) b_rd(2'(i), 16'h5AA5);

    a_wr(3'd2, 16'hABCD, 2'b11);
    a_wr(3'd2, 16'h1234, 2'b01);
    a_rd(3'd2, 16'hAB34);
    a_wr(3'd2, 16'hFFFF, 2'b00);
    a_rd(3'd2, 16'hAB34);
    a_wr(3'd3, 16'h9900, 2'b10);
    a_rd(3'd3, 16'h9900);

    a_exp(RDW_FULL);
    a_cyc(1'b1, 3'd1, 16'h005A, 2'b11, 1'b1, 3'd1);
    a_rd(3'd1, 16'h005A);
    a_exp(RDW_PART);
    a_cyc(1'b1, 3'd3, 16'h0011, 2'b01, 1'b1, 3'd3);
    a_rd(3'd3, 16'h9911);
    @(negedge clk);
    chk("a_addr_err_inrange", 32'(ifa.addr_err), 32'h0);
    nxt();

    // Both ports out of range in one cycle: one strobe, q forced to zero
    a_exp(16'h0000);
    a_cyc(1'b1, 3'd6, 16'hFFFF, 2'b11, 1'b1, 3'd7);
    @(negedge clk);
    chk("a_addr_err_both", 32'(ifa.addr_err), 32'h1);
    nxt();
    @(negedge clk);
    chk("a_addr_err_single_strobe", 32'(ifa.addr_err), 32'h0);
    nxt();
    a_wr(3'd5, 16'hEEEE, 2'b11);
    @(negedge clk);
    chk("a_addr_err_write", 32'(ifa.addr_err), 32'h1);
    nxt();
    a_rd(3'd0, 16'h0000);
    a_rd(3'd1, 16'h005A);
    a_rd(3'd2, 16'hAB34);
    a_rd(3'd3, 16'h9911);
    a_rd(3'd4, 16'h0000);

    b_wr(2'd0, 16'h1111);
    b_wr(2'd1, 16'h2222);
    b_wr(2'd2, 16'h3333);
    b_wr(2'd3, 16'h4444);
    b_rd(2'd0, 16'h1111);
    b_rd(2'd1, 16'h2222);
    b_rd(2'd2, 16'h3333);
    b_rd(2'd3, 16'h4444);
    repeat (2) nxt();

    // A read issued with clear_start still completes; then reset lands mid-sweep at address 2
    b_exp(16'h4444);
    b_cyc(1'b1, 1'b0, 2'd0, 16'h0, 2'b00, 1'b1, 2'd3);
    @(negedge clk);
    chk("b_busy_after_clear_start", 32'(ifb.busy), 32'h1);
    nxt();
    nxt();
    rst_b = 1'b1;
    nxt();
    @(negedge clk);
    chk("b_rst_mid_q", 32'(ifb.q), 32'h0);
    chk("b_rst_mid_q_valid", 32'(ifb.q_valid), 32'h0);
    nxt();
    rst_b = 1'b0;
    fork
      count_busy_b(nb);
      begin
        b_cyc(1'b1, 1'b0, 2'd0, 16'h0, 2'b00, 1'b0, 2'd0);
        b_cyc(1'b0, 1'b1, 2'd0, 16'hDEAD, 2'b11, 1'b1, 2'd1);
        b_cyc(1'b0, 1'b0, 2'd0, 16'h0, 2'b00, 1'b0, 2'd0);
        b_cyc(1'b1, 1'b1, 2'd0, 16'hDEAD, 2'b11, 1'b1, 2'd2);
      end
    join
    chk("b_busy_cycles_restart", 32'(nb), 32'd4);
    nxt();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("b_clear_start_ignored", 32'(ifb.busy), 32'h0);
      nxt();
    end
    for (int i = 0; i < 4; i++) b_rd(2'(i), 16'h5AA5);

    repeat (4) nxt();
    chk("a_scoreboard_drained", 32'(qa.size()), 32'd0);
    chk("b_scoreboard_drained", 32'(qb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
